// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the fetch/data memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;
  typedef enum logic {LAST_FETCH, LAST_DATA} last_t;
  localparam logic [31:0] TIMEOUT_DATA = 32'h0;
endpackage

// File: rtl/arb_timeout.sv
// arb_timeout: down-counter that flags the last allowed wait cycle of a transaction
module arb_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = TIMEOUT > 2 ? $clog2(TIMEOUT) : 1;
  // Loaded with TIMEOUT-2 so expiry lands on the (TIMEOUT-1)th request cycle
  localparam logic [W-1:0] LOAD = W'(TIMEOUT > 2 ? TIMEOUT - 2 : 0);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (clr) cnt <= LOAD;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  end
  assign expire = (TIMEOUT != 0) & en & (cnt == '0);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises MIPS fetch and data accesses onto one single-port memory
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  output logic        err,
  output logic        stall
);
  state_t state;
  last_t  last;
  logic   i_pend, d_pend, grant_i, grant_d, expire;
  // A port whose ready is pulsing still shows its stale request this cycle
  assign i_pend  = i_req & ~i_ready;
  assign d_pend  = (d_read | d_write) & ~d_ready;
  assign grant_d = d_pend & ~(i_pend & (last == LAST_DATA));
  assign grant_i = i_pend & ~grant_d;
  assign stall   = i_pend | d_pend;
  arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr   ((state == IDLE) & (grant_d | grant_i)),
    .en    ((state != IDLE) & ~m_ack),
    .expire(expire)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last    <= LAST_FETCH;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      err     <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      err     <= 1'b0;
      if (state == IDLE) begin
        if (grant_d) begin
          state   <= DATA;
          m_req   <= 1'b1;
          m_we    <= d_write;
          m_addr  <= d_addr;
          m_wdata <= d_wdata;
        end else if (grant_i) begin
          state  <= FETCH;
          m_req  <= 1'b1;
          m_we   <= 1'b0;
          m_addr <= i_addr;
        end
      end else if (m_ack || expire) begin
        state <= IDLE;
        m_req <= 1'b0;
        err   <= ~m_ack;
        if (state == FETCH) begin
          last    <= LAST_FETCH;
          i_ready <= 1'b1;
          i_rdata <= m_ack ? m_rdata : TIMEOUT_DATA;
        end else begin
          last    <= LAST_DATA;
          d_ready <= 1'b1;
          d_rdata <= !m_ack ? TIMEOUT_DATA : m_we ? d_rdata : m_rdata;
        end
      end
    end
  end
endmodule
